// File: rtl/band_dial_writer_pkg.sv
// Shared band-display definitions: band count, level width and reset level,
// plus the write-FSM state type used by the initiator.
package band_pkg;
  localparam int NUM_BANDS = 12;
  localparam int LEVEL_W   = 10;
  localparam int WDATA_W   = 16;

  typedef logic [3:0]         band_idx_t;
  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t    LEVEL_RESET = level_t'(412);
  localparam band_idx_t LAST_BAND   = band_idx_t'(NUM_BANDS - 1);

  typedef enum logic {IDLE, WRITE} wr_state_t;

  function automatic band_idx_t band_inc(input band_idx_t b);
    return (b == LAST_BAND) ? '0 : b + 4'd1;
  endfunction
endpackage

// File: rtl/band_dial_writer_if.sv
// Avalon-MM single-beat write channel between the band writer and the
// band display slave.
interface band_dial_writer_if
  import band_pkg::*;
  ();
  logic                 chipselect;
  logic                 write;
  band_idx_t            address;
  logic [WDATA_W-1:0]   writedata;
  logic                 waitrequest;

  modport master (output chipselect, output write, output address,
                  output writedata, input waitrequest);
  modport slave  (input chipselect, input write, input address,
                  input writedata, output waitrequest);
endinterface

// File: rtl/band_rr_arbiter.sv
// Find-first-set over the dirty vector, starting at ptr_i and wrapping at
// the last band, so every requester is served within NUM_BANDS grants.
module band_rr_arbiter
  import band_pkg::*;
(
  input  logic [NUM_BANDS-1:0] req_i,
  input  band_idx_t            ptr_i,
  output band_idx_t            sel_o,
  output logic                 any_o
);

  band_idx_t idx;

  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    idx   = ptr_i;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (!any_o && req_i[idx]) begin
        sel_o = idx;
        any_o = 1'b1;
      end
      idx = band_inc(idx);
    end
  end

endmodule

// File: rtl/band_dial_writer.sv
// Shadows the 12 band levels with dirty bits and pushes dirty bands to the
// display slave as single-beat Avalon-MM writes in round-robin order.
module band_dial_writer
  import band_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                level_valid,
  input  band_idx_t           level_band,
  input  level_t              level_data,
  input  logic                refresh,
  band_dial_writer_if.master  av,
  output logic                busy,
  output logic                band_err
);

  wr_state_t            state_q, state_d;
  level_t               level_q [NUM_BANDS];
  level_t               level_d [NUM_BANDS];
  logic [NUM_BANDS-1:0] dirty_q, dirty_d;
  band_idx_t            ptr_q, ptr_d;
  band_idx_t            addr_q, addr_d;
  logic [WDATA_W-1:0]   wdata_q, wdata_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;

  logic                 band_ok, upd, accept, any;
  logic [NUM_BANDS-1:0] upd_mask, req;
  band_idx_t            sel;
  level_t               sel_level;

  assign band_ok  = (level_band <= LAST_BAND);
  assign upd      = level_valid && band_ok;
  assign upd_mask = upd ? ({{(NUM_BANDS-1){1'b0}}, 1'b1} << level_band) : '0;
  assign accept   = (state_q == WRITE) && !av.waitrequest;

  // Incoming update/refresh is visible to the arbiter in the same cycle so
  // an idle writer launches on the very next edge.
  assign req = dirty_q | upd_mask | {NUM_BANDS{refresh}};

  band_rr_arbiter u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (sel),
    .any_o (any)
  );

  assign sel_level = (upd && (level_band == sel)) ? level_data : level_q[sel];

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    dirty_d  = dirty_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    err_d    = err_q;

    // Clear first so a same-cycle refresh or update re-marks the band.
    if (accept) dirty_d[addr_q] = 1'b0;
    if (refresh) dirty_d = '1;
    if (upd) begin
      dirty_d[level_band] = 1'b1;
      level_d[level_band] = level_data;
    end
    if (level_valid && !band_ok) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (any) begin
          addr_d   = sel;
          wdata_d  = {{(WDATA_W-LEVEL_W){1'b0}}, sel_level};
          strobe_d = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          strobe_d = 1'b0;
          ptr_d    = band_inc(addr_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= '{default: LEVEL_RESET};
      dirty_q  <= '1;
      ptr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      dirty_q  <= dirty_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign av.chipselect = strobe_q;
  assign av.write      = strobe_q;
  assign av.address    = addr_q;
  assign av.writedata  = wdata_q;
  assign busy          = (|dirty_q) || (state_q == WRITE);
  assign band_err      = err_q;

endmodule
